// File: rtl/al422_pkg.sv
// Shared AL422 frame-buffer types and default geometry, used by the write and readout stages.
package al422_pkg;

  typedef enum logic [1:0] {
    WRST,
    WAIT_SOF,
    WRITE
  } wr_state_t;

  localparam int AL422_FRAME_BYTES = 6144;
  localparam int AL422_WRST_CYCLES = 4;

endpackage

// File: rtl/al422_wr_strobe.sv
// AL422 write-port pin driver: one byte per two cycles (data+/WE, then WCK high), plus the /WRST rewind burst.
// Requests take effect on the next edge; rst_done is combinational so the FSM can leave WRST on the same edge.
module al422_wr_strobe #(
  parameter int WRST_CYCLES = 4
) (
  input  logic       in_clk,
  input  logic       in_nrst,
  input  logic       rst_req,
  input  logic       wr_req,
  input  logic [7:0] wr_data,
  output logic       rst_done,
  output logic       wck,
  output logic       we_n,
  output logic       wrst_n,
  output logic [7:0] data
);

  localparam int ECNT_W = $clog2(WRST_CYCLES + 1);
  localparam logic [ECNT_W-1:0] ECNT_LAST = ECNT_W'(WRST_CYCLES);

  logic              phase;
  logic [ECNT_W-1:0] ecnt;

  // The last counted rising edge leaves wck high, so finishing always drops wck with /WRST release.
  assign rst_done = rst_req && !wrst_n && (ecnt == ECNT_LAST);

  always_ff @(posedge in_clk or negedge in_nrst) begin
    if (!in_nrst) begin
      phase  <= 1'b0;
      wck    <= 1'b0;
      we_n   <= 1'b1;
      wrst_n <= 1'b1;
      data   <= '0;
      ecnt   <= '0;
    end else if (rst_req && !rst_done) begin
      we_n  <= 1'b1;
      phase <= 1'b0;
      // /WRST settles a full cycle before the first WCK rise.
      if (wrst_n) begin
        wrst_n <= 1'b0;
        wck    <= 1'b0;
      end else begin
        wck <= ~wck;
        if (!wck) begin
          ecnt <= ecnt + 1'b1;
        end
      end
    end else begin
      if (rst_done) begin
        wrst_n <= 1'b1;
        ecnt   <= '0;
      end
      if (phase) begin
        wck   <= 1'b1;
        phase <= 1'b0;
      end else begin
        wck <= 1'b0;
        if (wr_req) begin
          data  <= wr_data;
          we_n  <= 1'b0;
          phase <= 1'b1;
        end else begin
          we_n <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/al422_frame_writer.sv
// Frame writer into the AL422 FIFO: rewinds per frame, writes FRAME_BYTES bytes, flags done/abort.
// Two cycles per byte; in_ready is registered and drops during rewind, in-flight writes and held-byte replay.
module al422_frame_writer
  import al422_pkg::*;
#(
  parameter int FRAME_BYTES = AL422_FRAME_BYTES,
  parameter int CNT_W       = 13,
  parameter int WRST_CYCLES = AL422_WRST_CYCLES
) (
  input  logic       in_clk,
  input  logic       in_nrst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  input  logic       in_sof,
  output logic       in_ready,
  output logic       al422_wck_out,
  output logic       al422_we_out,
  output logic       al422_wrst_out,
  output logic [7:0] al422_data_out,
  output logic       frame_done,
  output logic       frame_abort
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_BYTES - 1);

  wr_state_t        state, state_d;
  logic [CNT_W-1:0] count, count_d;
  logic             pending, pending_d;
  logic             last_q, last_d;
  logic [7:0]       hold, hold_d;
  logic             ready_d, done_d, abort_d;
  logic             accept;
  logic             wr_req, rst_req, rst_done;
  logic [7:0]       wr_data;

  assign accept = in_valid & in_ready;

  always_comb begin
    state_d   = state;
    count_d   = count;
    pending_d = pending;
    last_d    = last_q;
    hold_d    = hold;
    done_d    = 1'b0;
    abort_d   = 1'b0;
    wr_req    = 1'b0;
    rst_req   = 1'b0;
    wr_data   = in_data;
    unique case (state)
      WRST: begin
        rst_req = 1'b1;
        if (rst_done) begin
          count_d = '0;
          if (pending) begin
            // Replay the byte that cut the previous frame short as byte 0.
            wr_req    = 1'b1;
            wr_data   = hold;
            pending_d = 1'b0;
            count_d   = CNT_W'(1);
            state_d   = WRITE;
          end else begin
            state_d = WAIT_SOF;
          end
        end
      end
      WAIT_SOF: begin
        if (accept && in_sof) begin
          wr_req  = 1'b1;
          count_d = CNT_W'(1);
          state_d = WRITE;
        end
      end
      WRITE: begin
        if (last_q && al422_wck_out) begin
          done_d  = 1'b1;
          last_d  = 1'b0;
          count_d = '0;
          state_d = WRST;
        end else if (accept) begin
          if (in_sof) begin
            hold_d    = in_data;
            pending_d = 1'b1;
            abort_d   = 1'b1;
            count_d   = '0;
            state_d   = WRST;
          end else begin
            wr_req = 1'b1;
            // Terminal byte parks the counter instead of stepping past FRAME_BYTES-1.
            if (count == LAST_IDX) begin
              last_d = 1'b1;
            end else begin
              count_d = count + 1'b1;
            end
          end
        end
      end
      default: state_d = WRST;
    endcase
    ready_d = ((state_d == WAIT_SOF) || (state_d == WRITE)) && !wr_req && !pending_d && !last_d;
  end

  always_ff @(posedge in_clk or negedge in_nrst) begin
    if (!in_nrst) begin
      state       <= WRST;
      count       <= '0;
      pending     <= 1'b0;
      last_q      <= 1'b0;
      hold        <= '0;
      in_ready    <= 1'b0;
      frame_done  <= 1'b0;
      frame_abort <= 1'b0;
    end else begin
      state       <= state_d;
      count       <= count_d;
      pending     <= pending_d;
      last_q      <= last_d;
      hold        <= hold_d;
      in_ready    <= ready_d;
      frame_done  <= done_d;
      frame_abort <= abort_d;
    end
  end

  al422_wr_strobe #(
    .WRST_CYCLES(WRST_CYCLES)
  ) u_strobe (
    .in_clk  (in_clk),
    .in_nrst (in_nrst),
    .rst_req (rst_req),
    .wr_req  (wr_req),
    .wr_data (wr_data),
    .rst_done(rst_done),
    .wck     (al422_wck_out),
    .we_n    (al422_we_out),
    .wrst_n  (al422_wrst_out),
    .data    (al422_data_out)
  );

endmodule

// File: doc/al422_frame_writer.md
Name: al422_frame_writer

Overview:
- Upstream stage of the AL422 frame buffer, on the write side.
- Accepts a byte stream from the video source using a valid/ready handshake and a start-of-frame marker.
- Generates the AL422 write-port signals: write reset, write enable, write clock and 8-bit data. Bytes land in the FIFO in the order the LED readout stage consumes them.
- Pulses frame_done after each complete frame. The top level uses it to start the readout stage.

Parameters:
- FRAME_BYTES, 6144, bytes per frame (must be ≥2 and ≤ 2^CNT_W).
- CNT_W, 13, byte-counter width.
- WRST_CYCLES, 4, number of al422_wck_out rising edges issued with al422_wrst_out low.

Ports:
- in_clk  input  1  system clock; all logic on its rising edge.
- in_nrst  input  1  reset, asynchronous, active-low.
- in_data  input  8  source byte.
- in_valid  input  1  in_data/in_sof valid.
- in_sof  input  1  marks the first byte of a frame; qualified by in_valid.
- in_ready  output  1  block accepts the byte this cycle (registered).
- al422_wck_out  output  1  AL422 WCK.
- al422_we_out  output  1  AL422 /WE, active-low.
- al422_wrst_out  output  1  AL422 /WRST, active-low.
- al422_data_out  output  8  AL422 DI.
- frame_done  output  1  one-cycle pulse after the last byte of a frame is clocked in.
- frame_abort  output  1  one-cycle pulse when a frame is cut short by an early in_sof.

Behaviour:
- Reset values: in_ready=0, al422_wck_out=0, al422_we_out=1, al422_wrst_out=1, al422_data_out=0, frame_done=0, frame_abort=0. Internal state: state=WRST, count=0, phase=0, pending=0.
- A byte is accepted on a cycle with in_valid&in_ready.
- in_ready is high only in WAIT_SOF or WRITE, with phase=0 and pending=0.
- Write timing (two cycles per byte):
  - Acceptance cycle: data registered to al422_data_out; al422_we_out=0 and phase=1 from the next cycle.
  - Next cycle: al422_wck_out=1 (rising edge while data and /WE are stable), phase returns to 0.
  - Following cycle: wck=0. /WE stays 0 only if another byte is accepted back-to-back, otherwise it returns to 1.
  - Maximum throughput is 1 byte per 2 in_clk cycles. With no valid byte, wck holds low.
- State WRST:
  - al422_wrst_out=0, al422_we_out=1, wck toggles every cycle.
  - After WRST_CYCLES rising edges of wck, drive wck=0 and wrst=1.
  - Then go to WAIT_SOF; count=0.
- State WAIT_SOF:
  - Bytes with in_sof=0 are accepted and discarded; no write occurs.
  - A byte with in_sof=1 is written as byte 0; count=1; go to WRITE.
- State WRITE:
  - Each accepted byte with in_sof=0 is written and count increments.
  - When the byte at count=FRAME_BYTES-1 completes its wck-high cycle, pulse frame_done on the next cycle, set count=0 and go to WRST (the FIFO is rewound for each frame).
- Early SOF in WRITE (in_sof=1 while count<FRAME_BYTES):
  - The byte is accepted into a holding register; pending=1.
  - Pulse frame_abort; no frame_done; go to WRST.
  - On leaving WRST with pending=1, the held byte is written as byte 0 without a handshake: pending=0, count=1, state WRITE.
- Simultaneous events: an in_sof on the last byte of a frame (count=FRAME_BYTES-1) is treated as early SOF, so frame_abort fires and frame_done does not.
- in_sof with in_valid=0 is ignored.
- Reset mid-operation: all outputs return to reset values immediately (asynchronously). The held byte is lost. Restart begins at WRST.
- Counter is CNT_W bits; compare against FRAME_BYTES-1; it never wraps past the terminal count.

Decomposition:
- Shared package al422_pkg holds:
  - the state type {WRST, WAIT_SOF, WRITE};
  - the default FRAME_BYTES and WRST_CYCLES constants, shared with the readout stage.
- One sub-module, al422_wr_strobe: owns phase, wck, /WE and data registers, and the WRST edge counter. It takes write/reset requests from the FSM and returns a done strobe.

Test Plan:
All scenarios use FRAME_BYTES=8, WRST_CYCLES=2.
1. Reset release, then in_valid=1, in_sof=1 with bytes 0x00..0x07 back-to-back:
   - First, exactly 2 wck edges with /WRST=0.
   - Then 8 writes, one every 2 cycles, DI=0x00..0x07 stable at each wck rise.
   - frame_done pulses once; then a new WRST sequence.
2. Bytes 0xAA, 0xBB with in_sof=0 before any sof:
   - Accepted (in_ready high) but no /WE low and no wck edge.
   - The next sof byte 0x11 is the first write.
3. Early SOF: sof frame, 3 bytes, then byte 0x55 with in_sof=1:
   - frame_abort pulses; WRST sequence; 0x55 written as first byte without a new handshake.
   - in_ready stays low until that write completes.
4. Gapped in_valid (1 cycle on, 3 off):
   - wck stays low during gaps; /WE low only in write cycles; count reaches 8 and frame_done pulses once.
5. Async reset asserted mid-frame, between in_clk edges:
   - Outputs return to reset values without a clock edge.
   - After release, the WRST sequence is repeated before any write.
6. sof on the 8th byte of a frame:
   - frame_abort pulses and frame_done does not; the byte becomes byte 0 of the next frame.
